// File: rtl/regfile_writeback.sv
// regfile_writeback: drives the register-file write port from ALU results
// and queued load responses, and tracks outstanding loads per register.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   alu_valid/rd/data   single-cycle ALU result (strict priority)
//   ld_issue/_rd        load issued, marks ld_issue_rd pending
//   ld_resp_*           load response push into FIFO (ready = !full)
//   we/writeAddr/...    registered register-file write port
//   busy                bit n set while a load to rn is outstanding
//   waw_err             sticky: ALU wrote a register with a pending load
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_issue_rd,
    input  logic          ld_resp_valid,
    output logic          ld_resp_ready,
    input  logic [AW-1:0] ld_resp_rd,
    input  logic [DW-1:0] ld_resp_data,
    output logic          we,
    output logic [AW-1:0] writeAddr,
    output logic [DW-1:0] writeData,
    output logic [15:0]   busy,
    output logic          waw_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULLN = (PW+1)'(DEPTH);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          push;
    logic          pop;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;

    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic [15:0]   busy_d;
    logic          waw_d;

    // Ready depends only on occupancy so the producer never sees a
    // combinational path through the ALU/pop decision.
    assign ld_resp_ready = (count != FULLN);
    assign push = ld_resp_valid && ld_resp_ready;
    assign pop  = !alu_valid && (count != '0);

    assign head_rd   = rd_mem[head];
    assign head_data = data_mem[head];

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= ld_resp_rd;
            data_mem[tail] <= ld_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Write-port selection; address/data hold when nothing is written.
    always_comb begin
        we_d   = 1'b0;
        addr_d = writeAddr;
        data_d = writeData;
        unique case (1'b1)
            alu_valid: begin
                we_d   = (alu_rd != '0);
                addr_d = alu_rd;
                data_d = alu_data;
            end
            pop: begin
                we_d   = (head_rd != '0);
                addr_d = head_rd;
                data_d = head_data;
            end
            default: ;
        endcase
    end

    // Clear on pop first, then set on issue so a same-bit collision
    // leaves the register pending.
    always_comb begin
        busy_d = busy;
        if (pop && head_rd != '0)
            busy_d[head_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != '0)
            busy_d[ld_issue_rd] = 1'b1;
    end

    assign waw_d = waw_err ||
                   (alu_valid && alu_rd != '0 && busy[alu_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            we        <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            busy      <= '0;
            waw_err   <= 1'b0;
        end else begin
            we        <= we_d;
            writeAddr <= addr_d;
            writeData <= data_d;
            busy      <= busy_d;
            waw_err   <= waw_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios for the writeback sequencer.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_rd;
    logic        ld_resp_valid;
    logic        ld_resp_ready;
    logic [3:0]  ld_resp_rd;
    logic [31:0] ld_resp_data;
    logic        we;
    logic [3:0]  writeAddr;
    logic [31:0] writeData;
    logic [15:0] busy;
    logic        waw_err;

    int checks = 0;
    int passed = 0;

    regfile_writeback #(.DEPTH(4), .AW(4), .DW(32)) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .ld_issue(ld_issue),
        .ld_issue_rd(ld_issue_rd),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_ready(ld_resp_ready),
        .ld_resp_rd(ld_resp_rd),
        .ld_resp_data(ld_resp_data),
        .we(we),
        .writeAddr(writeAddr),
        .writeData(writeData),
        .busy(busy),
        .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (we !== 1'b0) $display("FAIL rst_we got %b exp 0", we); else passed++;
        checks++; if (writeAddr !== 4'd0) $display("FAIL rst_addr got %h exp 0", writeAddr); else passed++;
        checks++; if (writeData !== 32'd0) $display("FAIL rst_data got %h exp 0", writeData); else passed++;
        checks++; if (busy !== 16'h0) $display("FAIL rst_busy got %h exp 0", busy); else passed++;
        checks++; if (waw_err !== 1'b0) $display("FAIL rst_waw got %b exp 0", waw_err); else passed++;
        checks++; if (ld_resp_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", ld_resp_ready); else passed++;
    endtask

    task automatic test_alu();
        alu_valid = 1'b1;
        alu_rd    = 4'd5;
        alu_data  = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        checks++; if (we !== 1'b1) $display("FAIL alu_we got %b exp 1", we); else passed++;
        checks++; if (writeAddr !== 4'd5) $display("FAIL alu_addr got %h exp 5", writeAddr); else passed++;
        checks++; if (writeData !== 32'hDEADBEEF) $display("FAIL alu_data got %h exp deadbeef", writeData); else passed++;
        tick();
        checks++; if (we !== 1'b0) $display("FAIL alu_we_off got %b exp 0", we); else passed++;
        checks++; if (writeData !== 32'hDEADBEEF) $display("FAIL alu_hold got %h exp deadbeef", writeData); else passed++;
    endtask

    task automatic test_r0();
        alu_valid = 1'b1;
        alu_rd    = 4'd0;
        alu_data  = 32'h1234;
        tick();
        alu_valid = 1'b0;
        checks++; if (we !== 1'b0) $display("FAIL r0_alu_we got %b exp 0", we); else passed++;
        checks++; if (writeData !== 32'h1234) $display("FAIL r0_alu_data got %h exp 1234", writeData); else passed++;
        ld_resp_valid = 1'b1;
        ld_resp_rd    = 4'd0;
        ld_resp_data  = 32'h5555;
        tick();
        ld_resp_valid = 1'b0;
        checks++; if (we !== 1'b0) $display("FAIL r0_push_we got %b exp 0", we); else passed++;
        tick();
        checks++; if (we !== 1'b0) $display("FAIL r0_pop_we got %b exp 0", we); else passed++;
        checks++; if (writeData !== 32'h5555) $display("FAIL r0_pop_data got %h exp 5555", writeData); else passed++;
        tick();
        checks++; if (we !== 1'b0) $display("FAIL r0_idle_we got %b exp 0", we); else passed++;
    endtask

    task automatic test_load_flow();
        ld_issue    = 1'b1;
        ld_issue_rd = 4'd3;
        tick();
        ld_issue = 1'b0;
        checks++; if (busy !== 16'h0008) $display("FAIL ld_busy_set got %h exp 0008", busy); else passed++;
        ld_resp_valid = 1'b1;
        ld_resp_rd    = 4'd3;
        ld_resp_data  = 32'hA5A5A5A5;
        tick();
        ld_resp_valid = 1'b0;
        checks++; if (we !== 1'b0) $display("FAIL ld_n1_we got %b exp 0", we); else passed++;
        checks++; if (busy !== 16'h0008) $display("FAIL ld_n1_busy got %h exp 0008", busy); else passed++;
        tick();
        checks++; if (we !== 1'b1) $display("FAIL ld_n2_we got %b exp 1", we); else passed++;
        checks++; if (writeAddr !== 4'd3) $display("FAIL ld_n2_addr got %h exp 3", writeAddr); else passed++;
        checks++; if (writeData !== 32'hA5A5A5A5) $display("FAIL ld_n2_data got %h exp a5a5a5a5", writeData); else passed++;
        checks++; if (busy !== 16'h0000) $display("FAIL ld_n2_busy got %h exp 0000", busy); else passed++;
        tick();
        checks++; if (we !== 1'b0) $display("FAIL ld_n3_we got %b exp 0", we); else passed++;
    endtask

    task automatic test_contention();
        logic        av [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  ar [5] = '{4'd1, 4'd2, 4'd4, 4'd0, 4'd0};
        logic        rv [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  rr [5] = '{4'd7, 4'd8, 4'd0, 4'd0, 4'd0};
        logic [3:0]  ea [5] = '{4'd1, 4'd2, 4'd4, 4'd7, 4'd8};
        logic [31:0] ed [5] = '{32'h11, 32'h22, 32'h44, 32'h77, 32'h88};
        for (int i = 0; i < 5; i++) begin
            alu_valid     = av[i];
            alu_rd        = ar[i];
            alu_data      = {28'd0, ar[i]} * 32'h11;
            ld_resp_valid = rv[i];
            ld_resp_rd    = rr[i];
            ld_resp_data  = {28'd0, rr[i]} * 32'h11;
            tick();
            checks++; if (we !== 1'b1) $display("FAIL cont_we[%0d] got %b exp 1", i, we); else passed++;
            checks++; if (writeAddr !== ea[i]) $display("FAIL cont_addr[%0d] got %h exp %h", i, writeAddr, ea[i]); else passed++;
            checks++; if (writeData !== ed[i]) $display("FAIL cont_data[%0d] got %h exp %h", i, writeData, ed[i]); else passed++;
        end
        alu_valid     = 1'b0;
        ld_resp_valid = 1'b0;
        tick();
        checks++; if (we !== 1'b0) $display("FAIL cont_end_we got %b exp 0", we); else passed++;
        checks++; if (busy !== 16'h0) $display("FAIL cont_busy got %h exp 0", busy); else passed++;
    endtask

    task automatic test_full();
        alu_valid = 1'b1;
        alu_rd    = 4'd10;
        alu_data  = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            ld_resp_valid = 1'b1;
            ld_resp_rd    = 4'(11 + i);
            ld_resp_data  = 32'hB0 + 32'(i);
            tick();
            checks++; if (ld_resp_ready !== (i < 3)) $display("FAIL full_ready[%0d] got %b exp %b", i, ld_resp_ready, (i < 3)); else passed++;
            checks++; if (writeAddr !== 4'd10) $display("FAIL full_alu_addr[%0d] got %h exp a", i, writeAddr); else passed++;
        end
        ld_resp_valid = 1'b0;
        alu_valid     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ld_resp_ready !== 1'b1) $display("FAIL drain_ready[%0d] got %b exp 1", i, ld_resp_ready); else passed++;
            checks++; if (we !== 1'b1) $display("FAIL drain_we[%0d] got %b exp 1", i, we); else passed++;
            checks++; if (writeAddr !== 4'(11 + i)) $display("FAIL drain_addr[%0d] got %h exp %h", i, writeAddr, 4'(11 + i)); else passed++;
            checks++; if (writeData !== 32'hB0 + 32'(i)) $display("FAIL drain_data[%0d] got %h exp %h", i, writeData, 32'hB0 + 32'(i)); else passed++;
        end
        tick();
        checks++; if (we !== 1'b0) $display("FAIL drain_end_we got %b exp 0", we); else passed++;
    endtask

    task automatic test_hazard_reset();
        ld_issue    = 1'b1;
        ld_issue_rd = 4'd9;
        tick();
        ld_issue = 1'b0;
        checks++; if (busy !== 16'h0200) $display("FAIL hz_busy got %h exp 0200", busy); else passed++;
        checks++; if (waw_err !== 1'b0) $display("FAIL hz_waw_pre got %b exp 0", waw_err); else passed++;
        alu_valid = 1'b1;
        alu_rd    = 4'd9;
        alu_data  = 32'h99;
        tick();
        alu_valid = 1'b0;
        checks++; if (waw_err !== 1'b1) $display("FAIL hz_waw got %b exp 1", waw_err); else passed++;
        checks++; if (we !== 1'b1) $display("FAIL hz_we got %b exp 1", we); else passed++;
        checks++; if (writeAddr !== 4'd9) $display("FAIL hz_addr got %h exp 9", writeAddr); else passed++;
        tick();
        checks++; if (waw_err !== 1'b1) $display("FAIL hz_sticky got %b exp 1", waw_err); else passed++;
        alu_valid     = 1'b1;
        alu_rd        = 4'd6;
        alu_data      = 32'h66;
        ld_resp_valid = 1'b1;
        ld_resp_rd    = 4'd9;
        ld_resp_data  = 32'h1;
        tick();
        ld_resp_rd   = 4'd2;
        ld_resp_data = 32'h2;
        tick();
        alu_valid     = 1'b0;
        ld_resp_valid = 1'b0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 16'h0) $display("FAIL hr_busy got %h exp 0", busy); else passed++;
        checks++; if (waw_err !== 1'b0) $display("FAIL hr_waw got %b exp 0", waw_err); else passed++;
        checks++; if (we !== 1'b0) $display("FAIL hr_we got %b exp 0", we); else passed++;
        checks++; if (ld_resp_ready !== 1'b1) $display("FAIL hr_ready got %b exp 1", ld_resp_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (we !== 1'b0) $display("FAIL hr_stale_we[%0d] got %b exp 0", i, we); else passed++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        ld_issue      = 1'b0;
        ld_issue_rd   = '0;
        ld_resp_valid = 1'b0;
        ld_resp_rd    = '0;
        ld_resp_data  = '0;
        #1;
        test_reset();
        test_alu();
        test_r0();
        test_load_flow();
        test_contention();
        test_full();
        test_hazard_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
